// File: rtl/number_splitter_pkg.sv
// ---------------------------------------------------------------------------
// number_splitter_pkg
// Shared definitions for the number splitter. The digit token encoding is the
// same one the keypad decoder and the number builder use, so tokens can be
// looped back between these blocks unchanged.
//
// Contents:
//   TOKEN_W        width of a digit token
//   TOK_0..TOK_9   digit token constants (value equals the digit)
//   splitState_t   splitter FSM states
//   digitToken()   maps a 0-9 digit to its token
// ---------------------------------------------------------------------------
package number_splitter_pkg;

  localparam int TOKEN_W = 4;

  localparam logic [TOKEN_W-1:0] TOK_0 = 4'd0;
  localparam logic [TOKEN_W-1:0] TOK_1 = 4'd1;
  localparam logic [TOKEN_W-1:0] TOK_2 = 4'd2;
  localparam logic [TOKEN_W-1:0] TOK_3 = 4'd3;
  localparam logic [TOKEN_W-1:0] TOK_4 = 4'd4;
  localparam logic [TOKEN_W-1:0] TOK_5 = 4'd5;
  localparam logic [TOKEN_W-1:0] TOK_6 = 4'd6;
  localparam logic [TOKEN_W-1:0] TOK_7 = 4'd7;
  localparam logic [TOKEN_W-1:0] TOK_8 = 4'd8;
  localparam logic [TOKEN_W-1:0] TOK_9 = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    COMMIT,
    EMIT,
    FINISH
  } splitState_t;

  // Digit tokens are numerically equal to the digit they carry.
  function automatic logic [TOKEN_W-1:0] digitToken(input logic [3:0] digit);
    return TOKEN_W'(digit);
  endfunction

endpackage

// File: rtl/number_splitter_div10_serial.sv
// ---------------------------------------------------------------------------
// number_splitter_div10_serial
// Restoring divider by the constant 10 that produces one quotient bit per
// clock, MSB first. A start strobe loads the dividend; the following WIDTH
// clocks each produce one quotient bit.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      load dividend and begin a new division
//   dividend   value to divide, sampled when start is high
//   quotient   dividend / 10, valid once the division has completed
//   remainder  dividend % 10, valid once the division has completed
//   done       high during the cycle whose clock edge computes the last
//              quotient bit, so the results are final the cycle after
// ---------------------------------------------------------------------------
module number_splitter_div10_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic [3:0]       remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // work_q starts out holding the dividend; each step shifts one dividend
  // bit out of the top and one quotient bit in at the bottom, so after WIDTH
  // steps it holds the complete quotient.
  logic [WIDTH-1:0] work_q, work_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             active_q, active_d;
  logic [4:0]       trial;

  // One restoring step: bring down the next dividend bit beside the running
  // remainder (the fifth bit is the guard bit, since 2*9+1 = 19 needs five
  // bits). Subtract 10 only when it fits, and record that as the quotient bit.
  always_comb begin
    trial    = {rem_q, work_q[WIDTH-1]};
    work_d   = work_q;
    rem_d    = rem_q;
    count_d  = count_q;
    active_d = active_q;
    if (start) begin
      work_d   = dividend;
      rem_d    = '0;
      count_d  = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (trial >= 5'd10) begin
        rem_d  = 4'(trial - 5'd10);
        work_d = {work_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = trial[3:0];
        work_d = {work_q[WIDTH-2:0], 1'b0};
      end
      count_d = count_q + 1'b1;
      if (count_q == LAST_STEP) begin
        active_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q   <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      work_q   <= work_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign quotient  = work_q;
  assign remainder = rem_q;
  assign done      = active_q && (count_q == LAST_STEP);

endmodule

// File: rtl/number_splitter.sv
// ---------------------------------------------------------------------------
// number_splitter
// Converts an unsigned binary value into decimal digit tokens, emitted most
// significant digit first over a valid/ready handshake. Digits are produced
// least significant first by repeated division by 10, stored in a small
// buffer, then read back out in reverse.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   load         start strobe, only honoured while idle
//   value        number to split, captured on an accepted load
//   token        current digit token (0-9)
//   token_valid  token holds a valid digit
//   token_ready  consumer takes the token when token_valid && token_ready
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last token is accepted
//   digit_count  digit count of the current or last conversion
// ---------------------------------------------------------------------------
module number_splitter #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10,
  parameter int TOKEN_W    = number_splitter_pkg::TOKEN_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   value,
  output logic [TOKEN_W-1:0] token,
  output logic               token_valid,
  input  logic               token_ready,
  output logic               busy,
  output logic               done,
  output logic [3:0]         digit_count
);

  import number_splitter_pkg::*;

  localparam int PTR_W = $clog2(MAX_DIGITS + 1);

  splitState_t        state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         digitCount_q, digitCount_d;
  logic [TOKEN_W-1:0] buffer_q [MAX_DIGITS];

  logic               divStart;
  logic [WIDTH-1:0]   divDividend;
  logic [WIDTH-1:0]   quotient;
  logic [3:0]         remainder;
  logic               divDone;
  logic               bufWrite;
  logic [PTR_W-1:0]   rdIdx;

  // The divider's shift register doubles as the working value N: it is
  // loaded with the input on load and reloaded with the quotient after each
  // committed digit, so no separate copy of N is kept here.
  number_splitter_div10_serial #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (divStart),
    .dividend (divDividend),
    .quotient (quotient),
    .remainder(remainder),
    .done     (divDone)
  );

  // Next-state logic. The divider is started on the same edge that enters
  // DIVIDE, which keeps each digit at exactly WIDTH divide cycles plus one
  // commit cycle. The pointer counts up while digits are collected and back
  // down while they are emitted, so the last digit found is sent first.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    digitCount_d = digitCount_q;
    divStart     = 1'b0;
    divDividend  = value;
    bufWrite     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          divStart     = 1'b1;
          divDividend  = value;
          ptr_d        = '0;
          digitCount_d = '0;
          state_d      = DIVIDE;
        end
      end
      DIVIDE: begin
        if (divDone) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        bufWrite = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (quotient == '0) begin
          digitCount_d = 4'(ptr_q + 1'b1);
          state_d      = EMIT;
        end else begin
          divStart    = 1'b1;
          divDividend = quotient;
          state_d     = DIVIDE;
        end
      end
      EMIT: begin
        if (token_ready) begin
          ptr_d = ptr_q - 1'b1;
          if (ptr_q == PTR_W'(1)) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, digit count and digit buffer. Reset wipes everything so
  // that releasing reset can never resume an interrupted conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      digitCount_q <= '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        buffer_q[i] <= TOK_0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      digitCount_q <= digitCount_d;
      if (bufWrite) begin
        buffer_q[ptr_q] <= digitToken(remainder);
      end
    end
  end

  // The presented token is read straight from the buffer, so it stays
  // stable for as long as the consumer stalls.
  assign rdIdx       = ptr_q - 1'b1;
  assign token       = (state_q == EMIT) ? buffer_q[rdIdx] : TOK_0;
  assign token_valid = (state_q == EMIT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign digit_count = digitCount_q;

  ptrBound: assert property (@(posedge clk) disable iff (reset)
                             ptr_q <= PTR_W'(MAX_DIGITS));

endmodule

// File: tb/tb_number_splitter.sv
// ---------------------------------------------------------------------------
// tb_number_splitter
// Self-checking bench for number_splitter. Expected digit sequences come
// from plain integer division of the loaded value; expected latency is
// digits * (WIDTH + 1) cycles from the load edge.
// ---------------------------------------------------------------------------
module tb_number_splitter;

  localparam int WIDTH  = 32;
  localparam int PER    = WIDTH + 1;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] value;
  logic [3:0]       token;
  logic             token_valid;
  logic             token_ready;
  logic             busy;
  logic             done;
  logic [3:0]       digit_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] expTokens[$];
  logic [3:0] gotTokens[$];
  int         gotLatency;
  logic [3:0] gotCount;
  int         stableBad;
  int         doneCount;
  int         doneGap;
  int         lastAccept;
  bit         timedOut;

  number_splitter #(
    .WIDTH(WIDTH),
    .MAX_DIGITS(10),
    .TOKEN_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .token      (token),
    .token_valid(token_valid),
    .token_ready(token_ready),
    .busy       (busy),
    .done       (done),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits of v, most significant first.
  task automatic buildExpected(input logic [31:0] v);
    longint unsigned x = 64'(v);
    expTokens.delete();
    do begin
      expTokens.push_front(4'(x % 10));
      x = x / 10;
    end while (x != 0);
  endtask

  function automatic string fmtTokens(input logic [3:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
    return s;
  endfunction

  // Pulse load for one clock; called at a falling edge while idle.
  task automatic applyStimulus(input logic [31:0] v);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
    value = $urandom;
  endtask

  // Drives token_ready for one conversion and records what comes out.
  // mode 0: always ready, 1: ready on every third valid cycle, 2: random.
  // injectAt >= 0 pulses load with injectVal on that cycle.
  task automatic runConversion(input int mode, input int injectAt,
                               input logic [31:0] injectVal);
    int cyc = 0;
    int k = 0;
    logic stalled = 1'b0;
    logic [3:0] heldTok = '0;
    logic r;
    gotTokens.delete();
    gotLatency = -1; gotCount = '0; stableBad = 0;
    doneCount = 0; doneGap = -1; lastAccept = -1; timedOut = 1'b0;
    while (busy === 1'b1 && cyc < BUDGET) begin
      if (cyc == injectAt) begin
        load = 1'b1; value = injectVal;
      end else begin
        load = 1'b0;
      end
      if (token_valid === 1'b1) begin
        if (gotLatency < 0) begin
          gotLatency = cyc; gotCount = digit_count;
        end
        if (stalled && token !== heldTok) stableBad++;
        case (mode)
          0:       r = 1'b1;
          1:       r = (k % 3 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        k++;
        token_ready = r; heldTok = token; stalled = !r;
        if (r) begin
          gotTokens.push_back(token); lastAccept = cyc;
        end
      end else begin
        token_ready = 1'($urandom_range(0, 1));
        stalled = 1'b0;
      end
      if (done === 1'b1) begin
        doneCount++; doneGap = cyc - lastAccept;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    load = 1'b0;
    token_ready = 1'b0;
    if (cyc >= BUDGET) timedOut = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; token_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({token, token_valid, busy, done, digit_count} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got tok=%0d v=%b busy=%b done=%b cnt=%0d expected all 0",
               token, token_valid, busy, done, digit_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    buildExpected(32'd1234);
    token_ready = 1'b1;
    applyStimulus(32'd1234);
    runConversion(0, -1, 0);
    total++;
    if (timedOut) begin bad++; $display("[TB] FAIL basic_timeout: got timeout expected finish"); end
    total++;
    if (fmtTokens(gotTokens) != fmtTokens(expTokens)) begin
      bad++; $display("[TB] FAIL basic_tokens: got %s expected %s", fmtTokens(gotTokens), fmtTokens(expTokens));
    end
    total++;
    if (gotLatency != 132) begin bad++; $display("[TB] FAIL basic_latency: got %0d expected 132", gotLatency); end
    total++;
    if (gotCount !== 4'd4) begin bad++; $display("[TB] FAIL basic_count: got %0d expected 4", gotCount); end
    total++;
    if (lastAccept - (gotLatency + 3) != 0) begin
      bad++; $display("[TB] FAIL basic_consecutive: got last accept %0d expected %0d", lastAccept, gotLatency + 3);
    end
    total++;
    if (doneCount != 1 || doneGap != 1) begin
      bad++; $display("[TB] FAIL basic_done: got pulses=%0d gap=%0d expected 1 and 1", doneCount, doneGap);
    end
    total++;
    if ({busy, done, token_valid} !== 3'b000 || digit_count !== 4'd4) begin
      bad++; $display("[TB] FAIL basic_idle_after: got busy=%b done=%b v=%b cnt=%0d expected 0 0 0 4",
                      busy, done, token_valid, digit_count);
    end
  endtask

  task automatic test_zero();
    buildExpected(32'd0);
    applyStimulus(32'd0);
    runConversion(0, -1, 0);
    total++;
    if (fmtTokens(gotTokens) != "0" || timedOut) begin
      bad++; $display("[TB] FAIL zero_tokens: got %s expected 0", fmtTokens(gotTokens));
    end
    total++;
    if (gotLatency != PER || gotCount !== 4'd1) begin
      bad++; $display("[TB] FAIL zero_timing: got lat=%0d cnt=%0d expected %0d and 1", gotLatency, gotCount, PER);
    end
    total++;
    if (doneCount != 1 || doneGap != 1) begin
      bad++; $display("[TB] FAIL zero_done: got pulses=%0d gap=%0d expected 1 and 1", doneCount, doneGap);
    end
  endtask

  task automatic test_max();
    buildExpected(32'hFFFF_FFFF);
    applyStimulus(32'hFFFF_FFFF);
    runConversion(0, -1, 0);
    total++;
    if (fmtTokens(gotTokens) != "4294967295" || timedOut) begin
      bad++; $display("[TB] FAIL max_tokens: got %s expected 4294967295", fmtTokens(gotTokens));
    end
    total++;
    if (gotLatency != 330 || gotCount !== 4'd10) begin
      bad++; $display("[TB] FAIL max_timing: got lat=%0d cnt=%0d expected 330 and 10", gotLatency, gotCount);
    end
  endtask

  task automatic test_stall();
    buildExpected(32'd907);
    applyStimulus(32'd907);
    runConversion(1, -1, 0);
    total++;
    if (fmtTokens(gotTokens) != fmtTokens(expTokens) || timedOut) begin
      bad++; $display("[TB] FAIL stall_tokens: got %s expected %s", fmtTokens(gotTokens), fmtTokens(expTokens));
    end
    total++;
    if (stableBad != 0) begin bad++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", stableBad); end
    total++;
    if (doneCount != 1 || doneGap != 1) begin
      bad++; $display("[TB] FAIL stall_done: got pulses=%0d gap=%0d expected 1 and 1", doneCount, doneGap);
    end
  endtask

  task automatic test_load_while_busy();
    int idleBad = 0;
    buildExpected(32'd55);
    applyStimulus(32'd55);
    runConversion(0, 10, 32'd88);
    total++;
    if (fmtTokens(gotTokens) != "55" || gotCount !== 4'd2) begin
      bad++; $display("[TB] FAIL busy_load_tokens: got %s cnt=%0d expected 55 cnt=2", fmtTokens(gotTokens), gotCount);
    end
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (busy !== 1'b0 || token_valid !== 1'b0) idleBad++;
    end
    total++;
    if (idleBad != 0) begin bad++; $display("[TB] FAIL busy_load_restart: got %0d busy cycles expected 0", idleBad); end
    buildExpected(32'd88);
    applyStimulus(32'd88);
    runConversion(0, -1, 0);
    total++;
    if (fmtTokens(gotTokens) != fmtTokens(expTokens)) begin
      bad++; $display("[TB] FAIL busy_load_second: got %s expected %s", fmtTokens(gotTokens), fmtTokens(expTokens));
    end
  endtask

  task automatic test_reset_midstream();
    int cyc = 0;
    int idleBad = 0;
    token_ready = 1'b1;
    applyStimulus(32'd4321);
    while (token_valid !== 1'b1 && cyc < BUDGET) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    total++;
    if (token_valid !== 1'b1 || token !== 4'd4) begin
      bad++; $display("[TB] FAIL midreset_first: got v=%b tok=%0d expected 1 and 4", token_valid, token);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (token !== 4'd3) begin bad++; $display("[TB] FAIL midreset_second: got %0d expected 3", token); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({token, token_valid, busy, done, digit_count} !== 11'd0) begin
      bad++; $display("[TB] FAIL midreset_outputs: got tok=%0d v=%b busy=%b done=%b cnt=%0d expected all 0",
                      token, token_valid, busy, done, digit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      token_ready = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      if (token_valid !== 1'b0 || busy !== 1'b0) idleBad++;
    end
    total++;
    if (idleBad != 0) begin bad++; $display("[TB] FAIL midreset_resume: got %0d active cycles expected 0", idleBad); end
    token_ready = 1'b1;
    applyStimulus(32'd6);
    runConversion(0, -1, 0);
    total++;
    if (fmtTokens(gotTokens) != "6" || gotCount !== 4'd1) begin
      bad++; $display("[TB] FAIL midreset_reload: got %s cnt=%0d expected 6 cnt=1", fmtTokens(gotTokens), gotCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int n = 0; n < 12; n++) begin
      v = $urandom >> $urandom_range(0, 31);
      buildExpected(v);
      applyStimulus(v);
      runConversion(2, -1, 0);
      total++;
      if (fmtTokens(gotTokens) != fmtTokens(expTokens) || timedOut) begin
        bad++; $display("[TB] FAIL rand_tokens[%0d]: got %s expected %s", n, fmtTokens(gotTokens), fmtTokens(expTokens));
      end
      total++;
      if (gotLatency != expTokens.size() * PER || int'(gotCount) != expTokens.size()) begin
        bad++; $display("[TB] FAIL rand_timing[%0d]: got lat=%0d cnt=%0d expected %0d and %0d",
                        n, gotLatency, gotCount, expTokens.size() * PER, expTokens.size());
      end
      total++;
      if (stableBad != 0 || doneCount != 1 || doneGap != 1) begin
        bad++; $display("[TB] FAIL rand_handshake[%0d]: got changes=%0d pulses=%0d gap=%0d expected 0 1 1",
                        n, stableBad, doneCount, doneGap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_stall();
    test_load_while_busy();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
